// File: rtl/b16_mem_pkg.sv
// b16_mem_pkg -- definitions shared by the 16-bit CPU memory-side blocks.
// Contents: the SRAM controller state encoding, the default number of ACCESS
// cycles, the default external word-address width, and the wait-counter
// width. It also provides a helper that turns a WAIT setting into the
// counter load value.
package b16_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } sram_state_e;

  localparam int WAIT_DEFAULT = 2;
  localparam int SRAM_AW      = 18;
  localparam int WAIT_CW      = 4;

  localparam logic [WAIT_CW-1:0] CNT_ZERO = {WAIT_CW{1'b0}};
  localparam logic [WAIT_CW-1:0] CNT_ONE  = {{(WAIT_CW-1){1'b0}}, 1'b1};

  // The counter counts down to zero inside ACCESS. A setting of 0 is treated
  // like 1, so both load zero and give a single ACCESS cycle.
  function automatic logic [WAIT_CW-1:0] wait_load(input int wait_cycles);
    if (wait_cycles <= 1) begin
      return CNT_ZERO;
    end else begin
      return WAIT_CW'(wait_cycles - 1);
    end
  endfunction

endpackage

// File: rtl/sram_wr_buf.sv
// sram_wr_buf -- one-entry posted-write buffer for sram_ctrl.
// Holds the word address, data and byte strobes of a write that the CPU has
// already been released from. valid is set on load and cleared on clear.
// Ports: clk, nreset (async, active-low); load/clear controls; addr/data/strb
// capture inputs; valid and q_addr/q_data/q_strb held outputs.
module sram_wr_buf (
  input  logic        clk,
  input  logic        nreset,
  input  logic        load,
  input  logic        clear,
  input  logic [14:0] addr,
  input  logic [15:0] data,
  input  logic [1:0]  strb,
  output logic        valid,
  output logic [14:0] q_addr,
  output logic [15:0] q_data,
  output logic [1:0]  q_strb
);

  logic        valid_r;
  logic [14:0] addr_r;
  logic [15:0] data_r;
  logic [1:0]  strb_r;

  // Capture one write entry; load takes priority over clear.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      valid_r <= 1'b0;
      addr_r  <= 15'h0000;
      data_r  <= 16'h0000;
      strb_r  <= 2'b00;
    end else if (load) begin
      valid_r <= 1'b1;
      addr_r  <= addr;
      data_r  <= data;
      strb_r  <= strb;
    end else if (clear) begin
      valid_r <= 1'b0;
    end
  end

  assign valid  = valid_r;
  assign q_addr = addr_r;
  assign q_data = data_r;
  assign q_strb = strb_r;

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl -- 16-bit asynchronous SRAM controller for the CPU bus.
// A request (sel & (r | |w)) runs IDLE -> SETUP -> ACCESS x WAIT -> DONE.
// Reads win over writes when both strobes are given. ready is high when no
// request is present and in DONE, and it is low otherwise during a request.
// All SRAM controls and the dq drive enable are registered from the
// next state, so they reach the pins without glitches.
// Ports: clk, nreset (async, active-low); CPU side sel, addr, r, w, wdata,
// rdata, ready, busy; SRAM side sram_dq, sram_addr, sram_ce_n, sram_oe_n,
// sram_we_n, sram_ub_n, sram_lb_n.
// Build option: define SRAM_CTRL_POSTED_WR_EN to post writes seen in IDLE
// through a one-entry buffer. The CPU is released in the same cycle, and the
// write runs in the background.
module sram_ctrl #(
  parameter int WAIT = b16_mem_pkg::WAIT_DEFAULT,
  parameter int AW   = b16_mem_pkg::SRAM_AW
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          sel,
  input  logic [15:0]   addr,
  input  logic          r,
  input  logic [1:0]    w,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata,
  output logic          ready,
  output logic          busy,
  inout  wire  [15:0]   sram_dq,
  output logic [AW-1:0] sram_addr,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic          sram_ub_n,
  output logic          sram_lb_n
);

  import b16_mem_pkg::*;

`ifdef SRAM_CTRL_POSTED_WR_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  sram_state_e        state_r, nxt_state_s;
  logic [WAIT_CW-1:0] cnt_r, nxt_cnt_s;
  logic [14:0]        addr_r;
  logic [15:0]        wdata_r, rdata_r;
  logic [1:0]         w_r, nxt_w_s, cur_w_s;
  logic               is_wr_r, nxt_is_wr_s, cur_is_wr_s;
  logic [14:0]        cur_addr_s;
  logic [15:0]        cur_wdata_s;
  logic               req_s, req_wr_s, load_s, posted_s, ready_s;
  logic               ce_n_r, oe_n_r, we_n_r, ub_n_r, lb_n_r, dq_oe_r, busy_r;
  logic               ce_n_s, oe_n_s, we_n_s, ub_n_s, lb_n_s, dq_oe_s;
  logic               addr_lsb_unused_s;

  // addr[0] is a byte select; the word-wide SRAM takes byte lanes from w.
  assign addr_lsb_unused_s = addr[0];

  assign req_s    = sel & (r | (|w));
  assign req_wr_s = req_s & ~r;

`ifdef SRAM_CTRL_POSTED_WR_EN
  logic        buf_vld_s;
  logic [14:0] buf_addr_s;
  logic [15:0] buf_data_s;
  logic [1:0]  buf_strb_s;

  sram_wr_buf u_wr_buf (
    .clk    (clk),
    .nreset (nreset),
    .load   ((state_r == ST_IDLE) & req_wr_s),
    .clear  (state_r == ST_DONE),
    .addr   (addr[15:1]),
    .data   (wdata),
    .strb   (w),
    .valid  (buf_vld_s),
    .q_addr (buf_addr_s),
    .q_data (buf_data_s),
    .q_strb (buf_strb_s)
  );

  // A valid buffer entry means the running transfer is a posted write.
  assign posted_s    = buf_vld_s;
  assign cur_addr_s  = buf_vld_s ? buf_addr_s : addr_r;
  assign cur_wdata_s = buf_vld_s ? buf_data_s : wdata_r;
  assign cur_w_s     = buf_vld_s ? buf_strb_s : w_r;
  assign cur_is_wr_s = buf_vld_s | is_wr_r;
`else
  assign posted_s    = 1'b0;
  assign cur_addr_s  = addr_r;
  assign cur_wdata_s = wdata_r;
  assign cur_w_s     = w_r;
  assign cur_is_wr_s = is_wr_r;
`endif

  // Next-state, wait-counter and transfer-latch decisions.
  always_comb begin
    nxt_state_s = state_r;
    nxt_cnt_s   = cnt_r;
    nxt_is_wr_s = cur_is_wr_s;
    nxt_w_s     = cur_w_s;
    load_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          nxt_state_s = ST_SETUP;
          nxt_is_wr_s = req_wr_s;
          nxt_w_s     = req_wr_s ? w : 2'b00;
          load_s      = ~(POSTED & req_wr_s);
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        nxt_state_s = ST_ACCESS;
        nxt_cnt_s   = wait_load(WAIT);
      end
      ST_ACCESS: begin
        if (cnt_r == CNT_ZERO) begin
          nxt_state_s = ST_DONE;
        end else begin
          nxt_cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_DONE: begin
        // A request held back by a posted write goes straight into SETUP.
        if (posted_s && req_s) begin
          nxt_state_s = ST_SETUP;
          nxt_is_wr_s = req_wr_s;
          nxt_w_s     = req_wr_s ? w : 2'b00;
          load_s      = 1'b1;
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      default: nxt_state_s = ST_IDLE;
    endcase
  end

  // SRAM pin values for the state being entered.
  always_comb begin
    ce_n_s  = 1'b1;
    oe_n_s  = 1'b1;
    we_n_s  = 1'b1;
    ub_n_s  = 1'b1;
    lb_n_s  = 1'b1;
    dq_oe_s = 1'b0;
    case (nxt_state_s)
      ST_SETUP: begin
        ce_n_s  = 1'b0;
        dq_oe_s = nxt_is_wr_s;
      end
      ST_ACCESS: begin
        ce_n_s = 1'b0;
        if (nxt_is_wr_s) begin
          we_n_s  = 1'b0;
          ub_n_s  = ~nxt_w_s[1];
          lb_n_s  = ~nxt_w_s[0];
          dq_oe_s = 1'b1;
        end else begin
          oe_n_s = 1'b0;
          ub_n_s = 1'b0;
          lb_n_s = 1'b0;
        end
      end
      ST_DONE: begin
        ce_n_s  = 1'b0;
        dq_oe_s = nxt_is_wr_s;
      end
      ST_IDLE: ce_n_s = 1'b1;
      default: ce_n_s = 1'b1;
    endcase
  end

  // CPU run gate: a posted write frees the CPU in IDLE and not in its DONE.
  always_comb begin
    ready_s = 1'b1;
    if (!req_s) begin
      ready_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: ready_s = POSTED & req_wr_s;
        ST_DONE: ready_s = ~posted_s;
        default: ready_s = 1'b0;
      endcase
    end
  end

  // State, counter, pin and read-data registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      rdata_r   <= 16'h0000;
      ce_n_r    <= 1'b1;
      oe_n_r    <= 1'b1;
      we_n_r    <= 1'b1;
      ub_n_r    <= 1'b1;
      lb_n_r    <= 1'b1;
      dq_oe_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r <= nxt_state_s;
      cnt_r   <= nxt_cnt_s;
      ce_n_r  <= ce_n_s;
      oe_n_r  <= oe_n_s;
      we_n_r  <= we_n_s;
      ub_n_r  <= ub_n_s;
      lb_n_r  <= lb_n_s;
      dq_oe_r <= dq_oe_s;
      busy_r  <= (nxt_state_s != ST_IDLE);
      // Sample the bus on the edge that leaves the last ACCESS cycle of a read.
      if ((state_r == ST_ACCESS) && (cnt_r == CNT_ZERO) && !cur_is_wr_s) begin
        rdata_r <= sram_dq;
      end
    end
  end

  // Latch the transfer when it is not held in the posted-write buffer.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      addr_r  <= 15'h0000;
      wdata_r <= 16'h0000;
      w_r     <= 2'b00;
      is_wr_r <= 1'b0;
    end else if (load_s) begin
      addr_r  <= addr[15:1];
      wdata_r <= wdata;
      w_r     <= nxt_w_s;
      is_wr_r <= nxt_is_wr_s;
    end
  end

  assign sram_dq   = dq_oe_r ? cur_wdata_s : 16'hzzzz;
  assign sram_addr = AW'(cur_addr_s);
  assign sram_ce_n = ce_n_r;
  assign sram_oe_n = oe_n_r;
  assign sram_we_n = we_n_r;
  assign sram_ub_n = ub_n_r;
  assign sram_lb_n = lb_n_r;
  assign rdata     = rdata_r;
  assign ready     = ready_s;
  assign busy      = busy_r;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl -- directed self-checking bench for sram_ctrl (WAIT=2, AW=18).
// A behavioural SRAM on the pins serves reads and takes byte-lane writes.
// Expected values are hand-computed constants.
// Define SRAM_CTRL_POSTED_WR_EN to build the posted-write variant.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        nreset, sel, r;
  logic [1:0]  w;
  logic [15:0] addr, wdata;
  logic [15:0] rdata;
  logic        ready, busy;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

`ifdef SRAM_CTRL_POSTED_WR_EN
  localparam int EXP_WR_RDY = 0;
`else
  localparam int EXP_WR_RDY = 4;
`endif

  sram_ctrl #(.WAIT(2), .AW(18)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .sel       (sel),
    .addr      (addr),
    .r         (r),
    .w         (w),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .busy      (busy),
    .sram_dq   (sram_dq),
    .sram_addr (sram_addr),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n),
    .sram_ub_n (sram_ub_n),
    .sram_lb_n (sram_lb_n)
  );

  always #5 clk = ~clk;

  // SRAM model
  logic [15:0] mem [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_idx = 10'd0;
  logic [15:0] pre_val = 16'h0000;
  wire  [9:0]  m_idx = sram_addr[9:0];
  wire  [4:0]  ctl = {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n};

  assign sram_dq = (!sram_ce_n && !sram_oe_n) ? mem[m_idx] : 16'hzzzz;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_idx] <= pre_val;
    end else if (!sram_ce_n && !sram_we_n) begin
      if (!sram_lb_n) mem[m_idx][7:0]  <= sram_dq[7:0];
      if (!sram_ub_n) mem[m_idx][15:8] <= sram_dq[15:8];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic preset(input logic [9:0] idx, input logic [15:0] val);
    pre_idx = idx;
    pre_val = val;
    pre_we  = 1'b1;
    @(posedge clk); #1;
    pre_we  = 1'b0;
  endtask

  // Results of the last xfer() call
  int          rc, we_cyc, oe_cyc;
  logic [1:0]  ubl_at_we;
  logic [15:0] dq_at_we;
  logic [17:0] addr_at_rdy;

  // Hold a request until the first ready, then drop it; observe 12 cycles.
  task automatic xfer(input logic rd, input logic [15:0] a, input logic [1:0] wr, input logic [15:0] d);
    rc = -1; we_cyc = 0; oe_cyc = 0; ubl_at_we = 2'b11; dq_at_we = 16'h0000; addr_at_rdy = 18'h0;
    sel = 1'b1; r = rd; w = wr; addr = a; wdata = d;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (!sram_we_n) begin
        we_cyc++;
        ubl_at_we = {sram_ub_n, sram_lb_n};
        dq_at_we  = sram_dq;
      end
      if (!sram_oe_n) oe_cyc++;
      if (sel && ready && rc < 0) begin
        rc = cyc;
        addr_at_rdy = sram_addr;
      end
      @(posedge clk); #1;
      if (rc >= 0) begin
        sel = 1'b0; r = 1'b0; w = 2'b00;
      end
    end
    sel = 1'b0; r = 1'b0; w = 2'b00;
  endtask

  int first, second, wcnt;

  initial begin
    nreset = 1'b0; sel = 1'b0; r = 1'b0; w = 2'b00; addr = 16'h0000; wdata = 16'h0000;
    @(posedge clk); #1;
    preset(10'h092, 16'hBEEF);
    preset(10'h100, 16'hABCD);
    preset(10'h101, 16'h00FF);
    preset(10'h180, 16'h1111);
    preset(10'h008, 16'hA5A5);
    preset(10'h009, 16'h5A5A);
    preset(10'h200, 16'h0000);

    // Reset state
    @(negedge clk);
    check("rst_ctl", 32'(ctl), 32'h1F);
    check("rst_ready", 32'(ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    @(posedge clk); #1;
    nreset = 1'b1;
    @(posedge clk); #1;

    // Basic read
    xfer(1'b1, 16'h0124, 2'b00, 16'h0000);
    check("rd_ready_cyc", 32'(rc), 32'd4);
    check("rd_oe_cycles", 32'(oe_cyc), 32'd2);
    check("rd_we_cycles", 32'(we_cyc), 32'd0);
    check("rd_rdata", 32'(rdata), 32'hBEEF);
    check("rd_sram_addr", 32'(addr_at_rdy), 32'h00092);

    // r together with w is a read
    xfer(1'b1, 16'h0200, 2'b11, 16'h0000);
    check("rw_ready_cyc", 32'(rc), 32'd4);
    check("rw_we_cycles", 32'(we_cyc), 32'd0);
    check("rw_rdata", 32'(rdata), 32'hABCD);
    check("rw_mem", 32'(mem[10'h100]), 32'hABCD);

    // Low-byte write
    xfer(1'b0, 16'h0200, 2'b01, 16'h1234);
    check("wr_ready_cyc", 32'(rc), 32'(EXP_WR_RDY));
    check("wr_we_cycles", 32'(we_cyc), 32'd2);
    check("wr_ub_lb", 32'(ubl_at_we), 32'h2);
    check("wr_dq", 32'(dq_at_we), 32'h1234);
    check("wr_mem", 32'(mem[10'h100]), 32'hAB34);

    // High-byte write
    xfer(1'b0, 16'h0202, 2'b10, 16'h9900);
    check("wrh_ready_cyc", 32'(rc), 32'(EXP_WR_RDY));
    check("wrh_ub_lb", 32'(ubl_at_we), 32'h1);
    check("wrh_mem", 32'(mem[10'h101]), 32'h99FF);

    // Not selected
    sel = 1'b0; r = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("nosel_ready", 32'(ready), 32'h1);
      check("nosel_ctl", 32'(ctl), 32'h1F);
      check("nosel_busy", 32'(busy), 32'h0);
      @(posedge clk); #1;
    end
    r = 1'b0;

    // Back-to-back reads
    first = -1; second = -1;
    sel = 1'b1; r = 1'b1; addr = 16'h0010;
    for (int cyc = 0; cyc < 20 && second < 0; cyc++) begin
      @(negedge clk);
      if (ready) begin
        if (first < 0) begin
          first = cyc;
          check("b2b_rdata0", 32'(rdata), 32'hA5A5);
        end else begin
          second = cyc;
          check("b2b_rdata1", 32'(rdata), 32'h5A5A);
        end
      end
      @(posedge clk); #1;
      if (first == cyc) addr = 16'h0012;
      if (second >= 0) begin sel = 1'b0; r = 1'b0; end
    end
    sel = 1'b0; r = 1'b0;
    check("b2b_first", 32'(first), 32'd4);
    check("b2b_second", 32'(second), 32'd9);

    // Reset during ACCESS of a write
    sel = 1'b1; w = 2'b11; addr = 16'h0300; wdata = 16'h5555;
    @(posedge clk); #1;
    sel = 1'b0; w = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstw_pre_we", 32'(sram_we_n), 32'h0);
    #1 nreset = 1'b0;
    #1;
    check("rstw_ctl", 32'(ctl), 32'h1F);
    check("rstw_rdata", 32'(rdata), 32'h0);
    check("rstw_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    nreset = 1'b1;
    repeat (4) @(posedge clk); #1;
    @(negedge clk);
    check("rstw_idle_busy", 32'(busy), 32'h0);
    check("rstw_idle_ctl", 32'(ctl), 32'h1F);
    check("rstw_mem", 32'(mem[10'h180]), 32'h1111);
    @(posedge clk); #1;

    // sel dropped after the first cycle: the write still completes
    sel = 1'b1; w = 2'b11; addr = 16'h0300; wdata = 16'h5555;
    @(posedge clk); #1;
    sel = 1'b0; w = 2'b00;
    wcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!sram_we_n) wcnt++;
      @(posedge clk); #1;
    end
    check("drop_we_cycles", 32'(wcnt), 32'd2);
    check("drop_mem", 32'(mem[10'h180]), 32'h5555);

`ifdef SRAM_CTRL_POSTED_WR_EN
    // Posted write followed at once by a read
    sel = 1'b1; r = 1'b0; w = 2'b11; addr = 16'h0400; wdata = 16'hC0DE;
    @(negedge clk);
    check("pw_ready0", 32'(ready), 32'h1);
    @(posedge clk); #1;
    r = 1'b1; w = 2'b00; addr = 16'h0010;
    rc = -1;
    for (int cyc = 1; cyc < 20 && rc < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check("pw_busy1", 32'(busy), 32'h1);
      if (ready) rc = cyc;
      @(posedge clk); #1;
    end
    sel = 1'b0; r = 1'b0;
    check("pw_read_ready_cyc", 32'(rc), 32'd8);
    check("pw_read_rdata", 32'(rdata), 32'hA5A5);
    check("pw_mem", 32'(mem[10'h200]), 32'hC0DE);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
